// File: rtl/regfile_mp.sv
// Multi-read-port register file with a zero-fill sweep after reset; ready flags sweep completion.
// Latency: 1 cycle per read port; writes visible on the next read (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none; clk_enable low freezes all state and holds rd_data.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_enable,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic              wr_ok;
    logic [DATA_W-1:0] mem [NUM_REGS];

    // Address is usable when it maps to real storage and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic in_range;
        in_range = ({1'b0, a} < (ADDR_W+1)'(NUM_REGS));
        return in_range && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign clr_last = (clr_cnt == ADDR_W'(NUM_REGS - 1));
    assign wr_ok    = (state_q == RUN) && wr_en && addr_ok(wr_addr);

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clk_enable && clr_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else if (clk_enable) begin
            state_q <= state_d;
            ready   <= (state_d == RUN);
            if (state_q == CLEAR && !clr_last)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Storage has no reset; the sweep is what guarantees X-free contents.
    always_ff @(posedge clk) begin
        if (clk_enable && !rst) begin
            if (state_q == CLEAR)
                mem[clr_cnt] <= '0;
            else if (wr_ok)
                mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] nxt;
        logic [DATA_W-1:0] q;

        assign a = rd_addr[g*ADDR_W +: ADDR_W];

        always_comb begin
            nxt = addr_ok(a) ? mem[a] : '0;
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (a == wr_addr))
                nxt = wr_data;
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                q <= '0;
            else if (clk_enable)
                q <= (state_q == CLEAR) ? '0 : nxt;
        end

        assign rd_data[g*DATA_W +: DATA_W] = q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 32-entry and a 24-entry instance share all inputs.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_enable;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data24;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        ready, ready24;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_READ(2), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready)
    );

    regfile_mp #(.DATA_W(32), .NUM_REGS(24), .NUM_READ(2), .ZERO_REG(1)) u_dut24 (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .rd_addr(rd_addr), .rd_data(rd_data24),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready24)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a0, a1;
        logic [31:0] e0, e1;   // 32-entry instance
        logic [31:0] f0, f1;   // 24-entry instance
    } vec_t;

    vec_t tbl [12];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic sweep(output int c32, output int c24, output bit rd_bad);
        c32 = 0;
        c24 = 0;
        rd_bad = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (!ready && rd_data !== 64'd0) rd_bad = 1'b1;
            if (!ready24 && rd_data24 !== 64'd0) rd_bad = 1'b1;
            if (ready && c32 == 0) c32 = i;
            if (ready24 && c24 == 0) c24 = i;
            if (c32 != 0) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  c32, c24;
        bit  rd_bad;

        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 5'd0,  32'h12345678, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[3]  = '{1'b1, 5'd7,  32'h1,        5'd1,  5'd2,  32'h0, 32'h0, 32'h0, 32'h0};
        tbl[4]  = '{1'b1, 5'd7,  32'h2,        5'd7,  5'd7,
                    BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h2, 32'h2, 32'h2, 32'h2};
        tbl[6]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[7]  = '{1'b1, 5'd30, 32'hFF,       5'd31, 5'd30, 32'hA5A5A5A5, BYP ? 32'hFF : 32'h0, 32'h0, 32'h0};
        tbl[8]  = '{1'b1, 5'd23, 32'h23,       5'd30, 5'd23, 32'hFF, BYP ? 32'h23 : 32'h0, 32'h0, BYP ? 32'h23 : 32'h0};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd23, 32'hFF, 32'h23, 32'h0, 32'h23};
        tbl[10] = '{1'b1, 5'd3,  32'h33,       5'd3,  5'd5,
                    BYP ? 32'h33 : 32'h0, 32'hDEADBEEF, BYP ? 32'h33 : 32'h0, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h33, 32'h33, 32'h33, 32'h33};

        rst = 1'b1;
        clk_enable = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        step();
        step();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_ready24", {31'd0, ready24}, 32'd0);
        chk("reset_rd0", rd_data[31:0], 32'd0);
        chk("reset_rd1", rd_data[63:32], 32'd0);

        rst = 1'b0;
        sweep(c32, c24, rd_bad);
        chk("sweep_cycles32", c32, 32);
        chk("sweep_cycles24", c24, 24);
        chk("sweep_rd_zero", {31'd0, rd_bad}, 32'd0);

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            step();
            chk($sformatf("clear_p0_a%0d", a), rd_data[31:0], 32'd0);
            chk($sformatf("clear_p1_a%0d", 31 - a), rd_data[63:32], 32'd0);
            chk($sformatf("clear24_p0_a%0d", a), rd_data24[31:0], 32'd0);
        end

        for (int i = 0; i < 12; i++) begin
            wr_en   = tbl[i].we;
            wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd;
            rd_addr = {tbl[i].a1, tbl[i].a0};
            step();
            chk($sformatf("vec%0d_p0", i), rd_data[31:0], tbl[i].e0);
            chk($sformatf("vec%0d_p1", i), rd_data[63:32], tbl[i].e1);
            chk($sformatf("vec%0d_d24_p0", i), rd_data24[31:0], tbl[i].f0);
            chk($sformatf("vec%0d_d24_p1", i), rd_data24[63:32], tbl[i].f1);
        end
        wr_en = 1'b0;

        // Stall: write and address changes must not take effect.
        rd_addr = {5'd5, 5'd3};
        step();
        clk_enable = 1'b0;
        wr_en = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'hAA;
        for (int k = 0; k < 3; k++) begin
            rd_addr = {5'(k + 8), 5'(k + 10)};
            step();
            chk($sformatf("stall%0d_p0", k), rd_data[31:0], 32'h33);
            chk($sformatf("stall%0d_p1", k), rd_data[63:32], 32'hDEADBEEF);
        end
        clk_enable = 1'b1;
        wr_en = 1'b0;
        rd_addr = {5'd3, 5'd3};
        step();
        chk("post_stall_r3", rd_data[31:0], 32'h33);
        chk("post_stall_d24_r3", rd_data24[63:32], 32'h33);

        // Reset asserted between edges must clear outputs immediately.
        rst = 1'b1;
        #2;
        chk("async_rst_rd0", rd_data[31:0], 32'd0);
        chk("async_rst_ready", {31'd0, ready}, 32'd0);
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #2;
        chk("midsweep_ready", {31'd0, ready}, 32'd0);
        step();
        rst = 1'b0;
        wr_en = 1'b1;
        wr_addr = 5'd4;
        wr_data = 32'h55;
        sweep(c32, c24, rd_bad);
        wr_en = 1'b0;
        chk("resweep_cycles32", c32, 32);
        chk("resweep_cycles24", c24, 24);
        chk("resweep_rd_zero", {31'd0, rd_bad}, 32'd0);

        rd_addr = {5'd7, 5'd4};
        step();
        chk("clear_wr_r4", rd_data[31:0], 32'd0);
        chk("clear_r7", rd_data[63:32], 32'd0);
        // The 24-entry copy finished its sweep early and accepted the held write.
        chk("d24_run_wr_r4", rd_data24[31:0], 32'h55);
        chk("d24_clear_r7", rd_data24[63:32], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
